adder_share_ctrl: RTL and testbench

- Arbitrates between two requesters for the single shared 16-bit carry-lookahead adder core in the ALU.
- Sequences narrow (16-bit) adds as one pass and wide (32-bit) adds as two passes, low half then high half, with the carry held between them.
- Returns each result over a valid/ready response port tagged with the requester ID.
- Sits between the ALU issue logic and the adder core; it is the only driver of the core's A, B and cin inputs.

---
 rtl/adder_share_ctrl_if.sv | 48 ++++
 rtl/adder_share_ctrl.sv | 134 +++++++++++++
 tb/tb_adder_share_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/adder_share_ctrl_if.sv
// Request/response bundle between the ALU issue logic and the shared-adder arbiter.
// The slave modport is the arbiter side and the master modport is the issue/consumer side.
interface adder_share_ctrl_if #(
    parameter int CNT_W = 8
);
    logic              req0_valid;
    logic              req0_ready;
    logic [31:0]       req0_a;
    logic [31:0]       req0_b;
    logic              req0_cin;
    logic              req0_wide;

    logic              req1_valid;
    logic              req1_ready;
    logic [31:0]       req1_a;
    logic [31:0]       req1_b;
    logic              req1_cin;
    logic              req1_wide;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [31:0]       rsp_sum;
    logic              rsp_cout;

    logic              busy;
    logic [CNT_W-1:0]  op_count;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_cin, req0_wide,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_cin, req1_wide,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_sum, rsp_cout,
        input  rsp_ready,
        output busy, op_count
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_cin, req0_wide,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_cin, req1_wide,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_sum, rsp_cout,
        output rsp_ready,
        input  busy, op_count
    );
endinterface

// File: rtl/adder_share_ctrl.sv
// Round-robin arbiter that time-shares one 16-bit adder core between two requesters.
// Wide adds run as two passes (low half, then high half) with the carry held in between.
module adder_share_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    adder_share_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_e;

    state_e            state_q, state_d;
    logic              ptr_q, ptr_d;
    logic [31:0]       a_q, a_d;
    logic [31:0]       b_q, b_d;
    logic [31:0]       sum_q, sum_d;
    logic              cin_q, cin_d;
    logic              wide_q, wide_d;
    logic              id_q, id_d;
    logic              carry_q, carry_d;
    logic [CNT_W-1:0]  opCount_q, opCount_d;

    logic [15:0]       coreA, coreB, coreSum;
    logic              coreCin, coreCout;
    logic              grantAny, grantId;
    logic              ready0, ready1;

    // The shared 16-bit core; this block is its only source of operands.
    assign {coreCout, coreSum} = {1'b0, coreA} + {1'b0, coreB} + {16'b0, coreCin};

    // A lone requester always wins; on contention the pointer picks the winner.
    assign grantAny = bus.req0_valid | bus.req1_valid;
    assign grantId  = bus.req1_valid & (~bus.req0_valid | ptr_q);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        cin_d     = cin_q;
        wide_d    = wide_q;
        id_d      = id_q;
        carry_d   = carry_q;
        opCount_d = opCount_q;
        coreA     = 16'h0000;
        coreB     = 16'h0000;
        coreCin   = 1'b0;
        ready0    = 1'b0;
        ready1    = 1'b0;

        case (state_q)
            IDLE: begin
                if (grantAny) begin
                    ready0  = ~grantId;
                    ready1  = grantId;
                    a_d     = grantId ? bus.req1_a    : bus.req0_a;
                    b_d     = grantId ? bus.req1_b    : bus.req0_b;
                    cin_d   = grantId ? bus.req1_cin  : bus.req0_cin;
                    wide_d  = grantId ? bus.req1_wide : bus.req0_wide;
                    id_d    = grantId;
                    ptr_d   = ~grantId;
                    state_d = LO;
                end
            end
            LO: begin
                coreA         = a_q[15:0];
                coreB         = b_q[15:0];
                coreCin       = cin_q;
                sum_d[15:0]   = coreSum;
                carry_d       = coreCout;
                if (wide_q) begin
                    state_d = HI;
                end else begin
                    sum_d[31:16] = 16'h0000;
                    state_d      = DONE;
                end
            end
            HI: begin
                coreA         = a_q[31:16];
                coreB         = b_q[31:16];
                coreCin       = carry_q;
                sum_d[31:16]  = coreSum;
                carry_d       = coreCout;
                state_d       = DONE;
            end
            DONE: begin
                if (bus.rsp_ready) begin
                    opCount_d = opCount_q + 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            ptr_q     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            sum_q     <= '0;
            cin_q     <= 1'b0;
            wide_q    <= 1'b0;
            id_q      <= 1'b0;
            carry_q   <= 1'b0;
            opCount_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sum_q     <= sum_d;
            cin_q     <= cin_d;
            wide_q    <= wide_d;
            id_q      <= id_d;
            carry_q   <= carry_d;
            opCount_q <= opCount_d;
        end
    end

    // Outputs are forced low while reset is held so nothing leaks out before state settles.
    assign bus.req0_ready = ready0 & ~reset;
    assign bus.req1_ready = ready1 & ~reset;
    assign bus.rsp_valid  = (state_q == DONE) & ~reset;
    assign bus.rsp_sum    = bus.rsp_valid ? sum_q : 32'h0000_0000;
    assign bus.rsp_cout   = bus.rsp_valid & carry_q;
    assign bus.rsp_id     = bus.rsp_valid & id_q;
    assign bus.busy       = (state_q != IDLE) & ~reset;
    assign bus.op_count   = reset ? '0 : opCount_q;

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Directed bench for adder_share_ctrl: vector table for single operations plus
// hand-written sequences for reset, contention, backpressure and mid-operation reset.
module tb_adder_share_ctrl;

    localparam int CNT_W = 8;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    adder_share_ctrl_if #(.CNT_W(CNT_W)) bus ();

    adder_share_ctrl #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic        id;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        wide;
        logic [31:0] expSum;
        logic        expCout;
    } vec_t;

    int               checks = 0;
    int               passes = 0;
    logic [CNT_W-1:0] expCount;
    vec_t             vecs[8];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    endtask

    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idleReqs();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    task automatic driveReq(input logic id, input logic [31:0] a, input logic [31:0] b,
                            input logic cin, input logic wide);
        if (id) begin
            bus.req1_valid = 1'b1;
            bus.req1_a     = a;
            bus.req1_b     = b;
            bus.req1_cin   = cin;
            bus.req1_wide  = wide;
        end else begin
            bus.req0_valid = 1'b1;
            bus.req0_a     = a;
            bus.req0_b     = b;
            bus.req0_cin   = cin;
            bus.req0_wide  = wide;
        end
    endtask

    // Waits (bounded) for the requester's ready; returns with the DUT still in the accepting cycle.
    task automatic waitGrant(input logic id, output bit got);
        logic rdy;
        got = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rdy = id ? bus.req1_ready : bus.req0_ready;
            if (rdy) begin
                got = 1'b1;
                break;
            end
            waitCycle();
        end
        checkOutput("grant", 32'(got), 32'd1);
    endtask

    task automatic applyStimulus(input vec_t v);
        int lat;
        bit gotReady;
        bit gotRsp;
        driveReq(v.id, v.a, v.b, v.cin, v.wide);
        #1;
        waitGrant(v.id, gotReady);
        if (!gotReady) begin
            idleReqs();
            return;
        end
        waitCycle();
        idleReqs();
        lat    = 1;
        gotRsp = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bus.rsp_valid) begin
                gotRsp = 1'b1;
                break;
            end
            waitCycle();
            lat++;
        end
        checkOutput("latency", gotRsp ? 32'(lat) : 32'd0, v.wide ? 32'd3 : 32'd2);
        checkOutput("rsp_sum", bus.rsp_sum, v.expSum);
        checkOutput("rsp_cout", 32'(bus.rsp_cout), 32'(v.expCout));
        checkOutput("rsp_id", 32'(bus.rsp_id), 32'(v.id));
        bus.rsp_ready = 1'b1;
        waitCycle();
        bus.rsp_ready = 1'b0;
        if (gotRsp) expCount++;
        checkOutput("op_count", 32'(bus.op_count), 32'(expCount));
        checkOutput("busy after rsp", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        logic        ids[4];
        int          nRsp;
        bit          gotReady;
        bit          gotRsp;
        bit          sawValid;
        logic [31:0] holdSum;

        vecs[0] = '{1'b0, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1};
        vecs[1] = '{1'b1, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b1, 32'h0001_0000, 1'b0};
        vecs[2] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_0000, 1'b1};
        vecs[3] = '{1'b0, 32'h1234_8000, 32'hABCD_8000, 1'b1, 1'b0, 32'h0000_0001, 1'b1};
        vecs[4] = '{1'b0, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1, 32'h2345_6789, 1'b0};
        vecs[5] = '{1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1};
        vecs[6] = '{1'b0, 32'h0001_FFFF, 32'h0000_FFFF, 1'b1, 1'b1, 32'h0002_FFFF, 1'b0};
        vecs[7] = '{1'b1, 32'h0000_1234, 32'h0000_4321, 1'b0, 1'b0, 32'h0000_5555, 1'b0};

        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_cin = 1'b0; bus.req0_wide = 1'b0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_cin = 1'b0; bus.req1_wide = 1'b0;
        bus.rsp_ready  = 1'b0;
        expCount       = '0;

        // Reset held two cycles with a pending request
        reset          = 1'b1;
        bus.req0_valid = 1'b1;
        waitCycle();
        checkOutput("req0_ready in reset", 32'(bus.req0_ready), 32'd0);
        waitCycle();
        reset = 1'b0;
        #1;
        checkOutput("rsp_valid after reset", 32'(bus.rsp_valid), 32'd0);
        checkOutput("op_count after reset", 32'(bus.op_count), 32'd0);
        checkOutput("busy after reset", 32'(bus.busy), 32'd0);
        checkOutput("req0_ready after reset", 32'(bus.req0_ready), 32'd1);
        idleReqs();
        waitCycle();

        // Contention: both valid, narrow, rsp_ready tied high for 12 cycles
        driveReq(1'b0, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0);
        driveReq(1'b1, 32'h0000_00F0, 32'h0000_000F, 1'b1, 1'b0);
        bus.rsp_ready = 1'b1;
        #1;
        nRsp = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.rsp_valid) begin
                if (nRsp < 4) ids[nRsp] = bus.rsp_id;
                checkOutput("contention sum", bus.rsp_sum, bus.rsp_id ? 32'h0000_0100 : 32'h0000_0003);
                nRsp++;
            end
            waitCycle();
        end
        idleReqs();
        bus.rsp_ready = 1'b0;
        expCount      = expCount + 8'd4;
        checkOutput("contention responses", 32'(nRsp), 32'd4);
        checkOutput("contention op_count", 32'(bus.op_count), 32'(expCount));
        if (nRsp == 4) begin
            checkOutput("grant order", {28'd0, ids[0], ids[1], ids[2], ids[3]}, 32'h0000_0005);
        end
        waitCycle();

        // Single operations from the table
        for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

        // Response backpressure with a competing request pending
        driveReq(1'b0, 32'h0000_ABCD, 32'h0000_1111, 1'b0, 1'b0);
        #1;
        waitGrant(1'b0, gotReady);
        waitCycle();
        idleReqs();
        gotRsp = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bus.rsp_valid) begin
                gotRsp = 1'b1;
                break;
            end
            waitCycle();
        end
        checkOutput("backpressure rsp_valid", 32'(gotRsp), 32'd1);
        driveReq(1'b1, 32'h0000_0002, 32'h0000_0003, 1'b0, 1'b0);
        holdSum = 32'h0000_BCDE;
        for (int i = 0; i < 5; i++) begin
            #1;
            checkOutput("hold rsp_valid", 32'(bus.rsp_valid), 32'd1);
            checkOutput("hold rsp_sum", bus.rsp_sum, holdSum);
            checkOutput("hold rsp_id/cout", {30'd0, bus.rsp_id, bus.rsp_cout}, 32'd0);
            checkOutput("hold no ready", {30'd0, bus.req0_ready, bus.req1_ready}, 32'd0);
            checkOutput("hold op_count", 32'(bus.op_count), 32'(expCount));
            waitCycle();
        end
        bus.rsp_ready = 1'b1;
        #1;
        checkOutput("no accept in DONE", 32'(bus.req1_ready), 32'd0);
        waitCycle();
        idleReqs();
        bus.rsp_ready = 1'b0;
        expCount++;
        checkOutput("backpressure op_count", 32'(bus.op_count), 32'(expCount));
        waitCycle();

        // Reset during the high pass of a wide operation
        reset = 1'b0;
        driveReq(1'b1, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1);
        #1;
        waitGrant(1'b1, gotReady);
        waitCycle();
        idleReqs();
        waitCycle();
        checkOutput("busy in HI", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        waitCycle();
        reset    = 1'b0;
        expCount = '0;
        #1;
        checkOutput("busy after mid reset", 32'(bus.busy), 32'd0);
        checkOutput("op_count after mid reset", 32'(bus.op_count), 32'd0);
        sawValid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (bus.rsp_valid) sawValid = 1'b1;
            waitCycle();
        end
        checkOutput("no rsp for discarded op", 32'(sawValid), 32'd0);
        applyStimulus(vecs[4]);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
